// File: rtl/i2c_target_ctrl.sv
`timescale 1ns/1ps
// i2c_target_ctrl: I2C target (slave) controller with a tx word handshake and
// an rx FIFO. It supports 7-bit and 10-bit (11110xx header) addressing.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on SCL and SDA after the synchronisers.
module i2c_target_ctrl #(
    parameter int                    ADDR_WIDTH    = 7,
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDRESS = 'h22,
    parameter int                    RX_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [4:0]            status
);
    localparam int SW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
    localparam int CW = $clog2(SW + 1);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] ADDR_BITS = CW'(8);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(RX_DEPTH);
    localparam logic [9:0]    ADDR10    = 10'(SLAVE_ADDRESS);
    localparam logic [6:0]    ADDR7     = 7'(SLAVE_ADDRESS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR2, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                state;
    logic                  scl_s1, scl_s2, sda_s1, sda_s2;
    logic                  scl_f, sda_f, scl_q, sda_q;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         sh;
    logic [DATA_WIDTH-1:0] txsh;
    logic                  need2, mack, busy, rd_op, addr_hit, tx_underflow, rx_overflow;
    logic [DATA_WIDTH-1:0] mem [RX_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    // Two-flop synchronisers; reset to 1 so an idle bus shows no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;
    // Majority of the last three synchronised samples; a 1-clk pulse never wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_s2};
            sda_hist <= {sda_hist[1:0], sda_s2};
            scl_f    <= (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
            sda_f    <= (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    // Previous-cycle line values for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, first_hit, second_hit;
    logic full, pop, push_req, push_ok;
    logic [CW-1:0] lim;
    assign scl_rise   = scl_f & ~scl_q;
    assign scl_fall   = ~scl_f & scl_q;
    assign start_c    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c     = scl_f & scl_q & ~sda_q & sda_f;
    assign first_hit  = (ADDR_WIDTH == 10) ? (sh[7:1] == {5'b11110, ADDR10[9:8]}) : (sh[7:1] == ADDR7);
    assign second_hit = (sh[7:0] == ADDR10[7:0]);
    assign lim        = (state == WR_DATA) ? DATA_BITS : ADDR_BITS;
    assign full       = (count == CNT_FULL);
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
    assign pop        = rx_valid & rx_ready;
    assign push_req   = ~start_c & ~stop_c & scl_fall & (state == WR_DATA) & (cnt == DATA_BITS);
    // A push into a full FIFO still lands when the head pops in the same cycle
    assign push_ok    = push_req & (~full | pop);
    assign status     = {busy, rd_op, addr_hit, tx_underflow, rx_overflow};

    // Bus protocol FSM: bits sampled on SCL rise, SDA driven only after SCL fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sh           <= '0;
            txsh         <= '0;
            sda_oe       <= 1'b0;
            tx_ready     <= 1'b0;
            need2        <= 1'b0;
            mack         <= 1'b1;
            busy         <= 1'b0;
            rd_op        <= 1'b0;
            addr_hit     <= 1'b0;
            tx_underflow <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            if (stop_c) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                addr_hit <= 1'b0;
            end else if (start_c) begin
                state        <= ADDR;
                cnt          <= '0;
                sda_oe       <= 1'b0;
                need2        <= 1'b0;
                busy         <= 1'b1;
                tx_underflow <= 1'b0;
                rx_overflow  <= 1'b0;
            end else begin
                // Word taken in the tx_ready cycle, MSB driven while SCL is still low
                if (tx_ready) begin
                    txsh   <= tx_valid ? tx_data : '1;
                    sda_oe <= tx_valid ? ~tx_data[DATA_WIDTH-1] : 1'b0;
                    if (!tx_valid) tx_underflow <= 1'b1;
                end
                if (scl_rise) begin
                    case (state)
                        ADDR, ADDR2, WR_DATA: if (cnt < lim) begin
                            sh  <= {sh[SW-2:0], sda_f};
                            cnt <= cnt + 1'b1;
                        end
                        RD_DATA: cnt  <= cnt + 1'b1;
                        RD_ACK:  mack <= sda_f;
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        ADDR: if (cnt == ADDR_BITS) begin
                            cnt <= '0;
                            if (first_hit) begin
                                state    <= ADDR_ACK;
                                sda_oe   <= 1'b1;
                                rd_op    <= sh[0];
                                need2    <= (ADDR_WIDTH == 10);
                                addr_hit <= addr_hit | (ADDR_WIDTH != 10);
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR2: if (cnt == ADDR_BITS) begin
                            cnt <= '0;
                            if (second_hit) begin
                                state    <= ADDR_ACK;
                                sda_oe   <= 1'b1;
                                need2    <= 1'b0;
                                addr_hit <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR_ACK: begin
                            cnt <= '0;
                            if (need2) begin
                                state  <= ADDR2;
                                sda_oe <= 1'b0;
                            end else if (rd_op) begin
                                state    <= RD_DATA;
                                tx_ready <= 1'b1;
                            end else begin
                                state  <= WR_DATA;
                                sda_oe <= 1'b0;
                            end
                        end
                        WR_DATA: if (cnt == DATA_BITS) begin
                            state  <= WR_ACK;
                            sda_oe <= push_ok;
                            if (!push_ok) rx_overflow <= 1'b1;
                        end
                        WR_ACK: begin
                            state  <= WR_DATA;
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                        end
                        RD_DATA: if (cnt == DATA_BITS) begin
                            state  <= RD_ACK;
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                        end else if (cnt != '0) begin
                            sda_oe <= ~txsh[DATA_WIDTH-2];
                            txsh   <= txsh << 1;
                        end
                        RD_ACK: if (!mack) begin
                            state    <= RD_DATA;
                            tx_ready <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            state <= IGNORE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Receive FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
        end
    end

    // Receive FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= sh[DATA_WIDTH-1:0];
    end
endmodule

// File: tb/tb_i2c_target_ctrl.sv
`timescale 1ns/1ps
// tb_i2c_target_ctrl: bus-level master model driving the target, with an
// expected-FIFO queue and per-transfer expectations derived from I2C rules.
module tb_i2c_target_ctrl;
    localparam int Q     = 10;   // clk cycles per quarter SCL period
    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic       tx_valid = 1'b0, rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus, sda_oe, tx_ready, rx_valid;
    logic [7:0] rx_data;
    logic [4:0] status;
    int         checks = 0, passes = 0, oe_cycles = 0, tx_pulses = 0;
    logic [7:0] model_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SLAVE_ADDRESS(7'h22), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .status(status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe)   oe_cycles <= oe_cycles + 1;
        if (tx_ready) tx_pulses <= tx_pulses + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(Q); scl_m = 1'b1; tick(2 * Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = sda_bus; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else passes++;
        checks++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else passes++;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) $display("FAIL reset_rx: got %b/%h want 0/00", rx_valid, rx_data); else passes++;
        checks++; if (status !== 5'b00000) $display("FAIL reset_status: got %b want 00000", status); else passes++;
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_write();
        logic       ack, exp_ack;
        logic [7:0] d, e;
        int         n;
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 2 : int'($urandom_range(3, 1));
            bus_start();
            write_byte(8'h44, ack);
            checks++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b want 1", ack); else passes++;
            for (int i = 0; i < n; i++) begin
                d = (r == 0) ? ((i == 0) ? 8'hA5 : 8'h3C) : 8'($urandom_range(255, 0));
                exp_ack = (model_q.size() < DEPTH);
                if (exp_ack) model_q.push_back(d);
                write_byte(d, ack);
                checks++; if (ack !== exp_ack) $display("FAIL wr_data_ack: byte %h got %b want %b", d, ack, exp_ack); else passes++;
            end
            checks++; if (status !== 5'b10100) $display("FAIL wr_status_busy: got %b want 10100", status); else passes++;
            bus_stop();
            checks++; if (status !== 5'b00000) $display("FAIL wr_status_idle: got %b want 00000", status); else passes++;
            while (model_q.size() > 0) begin
                e = model_q.pop_front();
                checks++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL wr_pop: got %b/%h want 1/%h", rx_valid, rx_data, e); else passes++;
                rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
            end
            checks++; if (rx_valid !== 1'b0) $display("FAIL wr_empty: got %b want 0", rx_valid); else passes++;
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] w [4];
        logic [7:0] d;
        int         n, p0;
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 2 : 3;
            for (int i = 0; i < 4; i++) w[i] = 8'($urandom_range(255, 0));
            if (r == 0) begin w[0] = 8'h5A; w[1] = 8'hC3; end
            p0 = tx_pulses;
            tx_valid = 1'b1;
            tx_data = w[0];
            bus_start();
            write_byte(8'h45, ack);
            checks++; if (ack !== 1'b1) $display("FAIL rd_addr_ack: got %b want 1", ack); else passes++;
            for (int i = 0; i < n; i++) begin
                tx_data = w[i + 1];
                read_byte(d, (i == n - 1));
                checks++; if (d !== w[i]) $display("FAIL rd_data: word %0d got %h want %h", i, d, w[i]); else passes++;
            end
            bus_stop();
            tx_valid = 1'b0;
            checks++; if (tx_pulses - p0 !== n) $display("FAIL rd_tx_pulses: got %0d want %0d", tx_pulses - p0, n); else passes++;
            checks++; if (status !== 5'b01000 || sda_oe !== 1'b0) $display("FAIL rd_end: got %b/%b want 01000/0", status, sda_oe); else passes++;
        end
    endtask

    task automatic test_addr_miss();
        logic       ack;
        logic [6:0] a;
        int         o0;
        for (int r = 0; r < 2; r++) begin
            a = 7'h23;
            if (r == 1) begin
                a = 7'($urandom_range(127, 0));
                while (a == 7'h22) a = 7'($urandom_range(127, 0));
            end
            o0 = oe_cycles;
            bus_start();
            write_byte({a, 1'b0}, ack);
            checks++; if (ack !== 1'b0) $display("FAIL miss_addr_nack: addr %h got %b want 0", a, ack); else passes++;
            write_byte(8'h11, ack);
            checks++; if (status[2] !== 1'b0) $display("FAIL miss_addr_hit: got %b want 0", status[2]); else passes++;
            bus_stop();
            checks++; if (oe_cycles !== o0) $display("FAIL miss_sda_oe: got %0d driven cycles want 0", oe_cycles - o0); else passes++;
            checks++; if (rx_valid !== 1'b0) $display("FAIL miss_rx_push: got %b want 0", rx_valid); else passes++;
        end
    endtask

    task automatic test_overflow();
        logic       ack, exp_ack;
        logic [7:0] d, e;
        rx_ready = 1'b0;
        bus_start();
        write_byte(8'h44, ack);
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(255, 0));
            exp_ack = (model_q.size() < DEPTH);
            if (exp_ack) model_q.push_back(d);
            write_byte(d, ack);
            checks++; if (ack !== exp_ack) $display("FAIL ovf_ack: byte %0d got %b want %b", i, ack, exp_ack); else passes++;
        end
        bus_stop();
        checks++; if (status[0] !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", status[0]); else passes++;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            checks++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL ovf_pop: got %b/%h want 1/%h", rx_valid, rx_data, e); else passes++;
            rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
        end
        checks++; if (rx_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", rx_valid); else passes++;
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        bus_start();
        write_byte(8'h44, ack);
        checks++; if (status[0] !== 1'b0) $display("FAIL rs_ovf_cleared: got %b want 0", status[0]); else passes++;
        write_byte(8'h01, ack);
        checks++; if (ack !== 1'b1) $display("FAIL rs_wr_ack: got %b want 1", ack); else passes++;
        tx_valid = 1'b0;
        bus_start();
        write_byte(8'h45, ack);
        checks++; if (ack !== 1'b1) $display("FAIL rs_rd_addr_ack: got %b want 1", ack); else passes++;
        read_byte(d, 1'b1);
        checks++; if (d !== 8'hFF) $display("FAIL rs_underflow_data: got %h want ff", d); else passes++;
        bus_stop();
        checks++; if (status !== 5'b01010) $display("FAIL rs_status: got %b want 01010", status); else passes++;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) $display("FAIL rs_buffered: got %b/%h want 1/01", rx_valid, rx_data); else passes++;
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
    endtask

    task automatic test_reset_mid_ack();
        logic       ack, b;
        logic [7:0] d, e;
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(logic'((8'h44 >> i) & 8'h01));
        sda_m = 1'b1;
        checks++; if (sda_oe !== 1'b1) $display("FAIL rst_ack_driven: got %b want 1", sda_oe); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rst_async_release: got %b want 0", sda_oe); else passes++;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        read_bit(b);
        checks++; if (b !== 1'b1) $display("FAIL rst_no_ack_after: got %b want 1", b); else passes++;
        write_byte(8'h44, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rst_no_ack_without_start: got %b want 0", ack); else passes++;
        bus_stop();
        d = 8'($urandom_range(255, 0));
        bus_start();
        write_byte(8'h44, ack);
        checks++; if (ack !== 1'b1) $display("FAIL rst_next_addr_ack: got %b want 1", ack); else passes++;
        model_q.push_back(d);
        write_byte(d, ack);
        checks++; if (ack !== 1'b1) $display("FAIL rst_next_data_ack: got %b want 1", ack); else passes++;
        bus_stop();
        e = model_q.pop_front();
        checks++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL rst_next_pop: got %b/%h want 1/%h", rx_valid, rx_data, e); else passes++;
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_miss();
        test_overflow();
        test_repeated_start();
        test_reset_mid_ack();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
